fetch_unit: RTL and testbench

- Instruction-fetch stage. Owns the PC, issues in-order requests to instruction memory over a valid/ready request and valid-only response interface, and buffers returned instructions with their PCs.
- Supplies {pc, instruction, valid} to the IF/ID pipeline register under backpressure from decode.
- Handles PC redirects from branch/jump resolution, discarding wrong-path words still in flight.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          FETCH_DEPTH      = 2;
  localparam int          DROP_W           = 8;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_W = cnt_width(FETCH_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; used both as the PC queue and the instruction buffer.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        push,
  input  fetch_entry_t                push_data,
  input  logic                        pop,
  output fetch_entry_t                head,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        empty,
  output logic                        full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, credit-limited memory requests, response buffering
// and redirect handling with drop accounting for wrong-path words still in flight.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        id_ready,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out
);

  localparam int CW = cnt_width(DEPTH);

  logic [31:0]       fetch_pc;
  logic [CW-1:0]     outstanding;
  logic [DROP_W-1:0] drop_cnt;

  fetch_entry_t      pcq_in;
  fetch_entry_t      pcq_head;
  logic [CW-1:0]     pcq_count;
  logic              pcq_empty;
  logic              pcq_full;

  fetch_entry_t      buf_in;
  fetch_entry_t      buf_head;
  logic [CW-1:0]     buf_count;
  logic              buf_empty;
  logic              buf_full;

  logic              credit_ok;
  logic              req_fire;
  logic              rsp_drop;
  logic              rsp_keep;
  logic              buf_pop;

  // Buffered plus in-flight words never exceed DEPTH, so every kept response has a slot.
  assign credit_ok      = (int'(buf_count) + int'(outstanding)) < DEPTH;
  assign imem_req_valid = rst_n && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign buf_pop  = valid_out && id_ready && !redirect_valid;

  assign valid_out       = !buf_empty;
  assign pc_out          = valid_out ? buf_head.pc   : '0;
  assign instruction_out = valid_out ? buf_head.insn : '0;

  always_comb begin
    pcq_in      = '0;
    pcq_in.pc   = fetch_pc;
    buf_in      = pcq_head;
    buf_in.insn = imem_rsp_data;
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_pc_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (pcq_in),
    .pop       (rsp_keep),
    .head      (pcq_head),
    .count     (pcq_count),
    .empty     (pcq_empty),
    .full      (pcq_full)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_insn_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (buf_in),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_count),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  // On redirect every live request becomes a wrong-path word to be swallowed later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc & 32'hFFFF_FFFC;
      outstanding <= '0;
      drop_cnt    <= drop_cnt + DROP_W'(outstanding) - DROP_W'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - DROP_W'(1);
      end
    end
  end

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding != '0 || drop_cnt != '0));
  a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    imem_req_addr[1:0] == 2'b00);
  a_pcq_tracks:   assert property (@(posedge clk) disable iff (!rst_n)
    pcq_count == outstanding);
  a_pcq_room:     assert property (@(posedge clk) disable iff (!rst_n)
    req_fire |-> !pcq_full);
  a_pcq_has_pc:   assert property (@(posedge clk) disable iff (!rst_n)
    rsp_keep |-> !pcq_empty);
  a_buf_room:     assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_keep && !buf_pop) |-> !buf_full);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model with epoch tags and an expected-output queue.
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_ready;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  exp_t        exp_q[$];
  mreq_t       mem_q[$];
  int          cyc;
  int          epoch;
  int          mb;
  int          lat;
  int          pops;
  int          checks;
  int          failures;
  logic [31:0] exp_pc;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .id_ready        (id_ready),
    .valid_out       (valid_out),
    .pc_out          (pc_out),
    .instruction_out (instruction_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic resetModel();
    exp_q.delete();
    mem_q.delete();
    mb     = 0;
    epoch++;
    exp_pc = RESET_PC;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    checkOutput({tag, "_valid_out"}, 32'(valid_out), 32'd0);
    checkOutput({tag, "_pc_out"}, pc_out, 32'd0);
    checkOutput({tag, "_insn_out"}, instruction_out, 32'd0);
  endtask

  // Called at posedge+1: drive one cycle of inputs, check at negedge, update the model for the edge.
  task automatic applyStimulus(input logic redir, input logic [31:0] rpc,
                               input logic rdy, input logic idr);
    mreq_t m;
    logic  exp_rv;
    logic  keep;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    id_ready       = idr;
    keep           = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m              = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memword(m.addr);
      keep           = (m.epoch == epoch) && !redir;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    exp_rv = !redir && (exp_q.size() < DEPTH);
    checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (imem_req_valid && exp_rv) checkOutput("req_addr", imem_req_addr, exp_pc);
    checkOutput("valid_out", 32'(valid_out), 32'(mb > 0));
    if (mb > 0) begin
      checkOutput("pc_out", pc_out, exp_q[0].pc);
      checkOutput("insn_out", instruction_out, exp_q[0].insn);
    end else begin
      checkOutput("pc_out_idle", pc_out, 32'd0);
      checkOutput("insn_out_idle", instruction_out, 32'd0);
    end
    if (imem_req_valid && rdy) mem_q.push_back('{imem_req_addr, cyc + lat, epoch});
    if (redir) begin
      exp_q.delete();
      mb     = 0;
      epoch++;
      exp_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (mb > 0 && idr) begin
        void'(exp_q.pop_front());
        mb--;
        pops++;
      end
      if (keep) mb++;
      if (exp_rv && rdy) begin
        exp_q.push_back('{exp_pc, memword(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    cyc            = 0;
    epoch          = 0;
    pops           = 0;
    lat            = 1;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    id_ready       = 1'b0;
    resetModel();

    #12;
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] sequential fetch");
    repeat (8) applyStimulus(1'b0, '0, 1'b1, 1'b1);

    $display("[TB] decode stall");
    repeat (5) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    repeat (6) applyStimulus(1'b0, '0, 1'b1, 1'b1);

    $display("[TB] redirect with two in flight");
    repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    lat = 3;
    repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    lat = 1;
    repeat (10) applyStimulus(1'b0, '0, 1'b1, 1'b1);

    $display("[TB] redirect colliding with a response, then back-to-back");
    for (int i = 0; i < 10 && mem_q.size() == 0; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0000_0180, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b1);
    repeat (12) applyStimulus(1'b0, '0, 1'b1, 1'b1);

    $display("[TB] address wrap with toggling ready");
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, (i % 2 == 0), 1'b1);

    $display("[TB] asynchronous reset with a full buffer");
    repeat (6) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    imem_rsp_valid = 1'b0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) applyStimulus(1'b0, '0, 1'b1, 1'b1);

    checkOutput("enough_pops", 32'(pops >= 15), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
